// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU core: FSM states, instruction
// field positions, jump-bit indices and the ALU function-code layout.
package hack_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 15;

  // Instruction field bit positions
  localparam int unsigned IR_CI_BIT  = 15;
  localparam int unsigned IR_A_BIT   = 12;
  localparam int unsigned IR_FN_MSB  = 11;
  localparam int unsigned IR_FN_LSB  = 6;
  localparam int unsigned IR_D1_BIT  = 5;
  localparam int unsigned IR_D2_BIT  = 4;
  localparam int unsigned IR_D3_BIT  = 3;
  localparam int unsigned IR_JMP_MSB = 2;
  localparam int unsigned IR_JMP_LSB = 0;

  // Jump-bit indices within the 3-bit jump field, and the unconditional code
  localparam int unsigned JMP_LT_IDX = 2;
  localparam int unsigned JMP_EQ_IDX = 1;
  localparam int unsigned JMP_GT_IDX = 0;
  localparam logic [2:0]  JMP_ALWAYS = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MREAD  = 3'd2,
    ST_MWRITE = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // ALU control bits in instruction order (IR[11] down to IR[6])
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_fn_t;

endpackage

// File: rtl/alu.sv
// Team Hack ALU: zero/negate each input, add or AND, optionally negate result.
module alu
  import hack_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  alu_fn_t           fn,
  output logic [WORD_W-1:0] out_c,
  output logic              zr_c,
  output logic              ng_c
);

  logic [WORD_W-1:0] xs;
  logic [WORD_W-1:0] ys;
  logic [WORD_W-1:0] res;

  // Operand preconditioning, function select and status flags
  always_comb begin
    xs = fn.zx ? '0 : x;
    if (fn.nx) xs = ~xs;
    ys = fn.zy ? '0 : y;
    if (fn.ny) ys = ~ys;
    res = fn.f ? (xs + ys) : (xs & ys);
    if (fn.no) res = ~res;
    out_c = res;
    zr_c  = (res == '0);
    ng_c  = res[WORD_W-1];
  end

endmodule

// File: rtl/hack_pc.sv
// Program counter register: parallel load, increment with natural 15-bit wrap.
module hack_pc
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Load has priority over increment; otherwise hold
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/hack_cpu_core.sv
// Multi-cycle Hack CPU core with handshaked data memory.
// Optional: define HACK_HALT_DETECT_EN to stop the core on a tight
// unconditional jump loop (jump to pc or pc-1); otherwise halted is tied 0.
module hack_cpu_core
  import hack_pkg::*;
#(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [14:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_re,
  output logic        dmem_we,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [14:0] pc,
  output logic        halted
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] areg_q, areg_d;
  logic [WORD_W-1:0] dreg_q, dreg_d;
  logic [WORD_W-1:0] wbuf_q, wbuf_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic              dmem_re_q, dmem_re_d;
  logic              dmem_we_q, dmem_we_d;

  logic              pc_load;
  logic              pc_inc;
  logic              commit;
  logic [WORD_W-1:0] alu_y;
  logic [WORD_W-1:0] alu_out;
  logic              alu_zr;
  logic              alu_ng;
  alu_fn_t           alu_fn;
  logic [2:0]        jmp_bits;
  logic              jump_hit;

  // Instruction decode and ALU operand select (M is the read data on the ack cycle)
  assign alu_fn   = alu_fn_t'(ir_q[IR_FN_MSB:IR_FN_LSB]);
  assign jmp_bits = ir_q[IR_JMP_MSB:IR_JMP_LSB];
  assign alu_y    = ir_q[IR_A_BIT] ? dmem_rdata : areg_q;
  assign jump_hit = (jmp_bits[JMP_LT_IDX] & alu_ng) |
                    (jmp_bits[JMP_EQ_IDX] & alu_zr) |
                    (jmp_bits[JMP_GT_IDX] & ~alu_ng & ~alu_zr);

  alu u_alu (
    .x     (dreg_q),
    .y     (alu_y),
    .fn    (alu_fn),
    .out_c (alu_out),
    .zr_c  (alu_zr),
    .ng_c  (alu_ng)
  );

  hack_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (areg_q[ADDR_W-1:0]),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // Next-state, register updates and bus-output staging
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    areg_d  = areg_q;
    dreg_d  = dreg_q;
    wbuf_d  = wbuf_q;
    waddr_d = waddr_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    commit  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ir_d    = imem_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!ir_q[IR_CI_BIT]) begin
          areg_d  = {1'b0, ir_q[IR_CI_BIT-1:0]};
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end else if (ir_q[IR_A_BIT]) begin
          state_d = ST_MREAD;
        end else begin
          commit = 1'b1;
        end
      end
      ST_MREAD: begin
        if (dmem_ack) commit = 1'b1;
      end
      ST_MWRITE: begin
        if (dmem_ack) state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Commit uses the pre-update A for both jump target and write address
    if (commit) begin
      if (ir_q[IR_D1_BIT]) areg_d = alu_out;
      if (ir_q[IR_D2_BIT]) dreg_d = alu_out;
      pc_load = jump_hit;
      pc_inc  = ~jump_hit;
      if (ir_q[IR_D3_BIT]) begin
        wbuf_d  = alu_out;
        waddr_d = areg_q[ADDR_W-1:0];
        state_d = ST_MWRITE;
      end else begin
        state_d = ST_FETCH;
      end
`ifdef HACK_HALT_DETECT_EN
      // Tight self-loop: freeze pc where it is and stop
      if ((jmp_bits == JMP_ALWAYS) &&
          ((areg_q[ADDR_W-1:0] == pc) ||
           (areg_q[ADDR_W-1:0] == (pc - ADDR_W'(1))))) begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        state_d = ST_HALT;
      end
`endif
    end
  end

  // Bus outputs are registered from the state being entered
  always_comb begin
    dmem_re_d   = (state_d == ST_MREAD);
    dmem_we_d   = (state_d == ST_MWRITE);
    dmem_addr_d = dmem_addr_q;
    if (state_d == ST_MREAD) begin
      dmem_addr_d = areg_d[ADDR_W-1:0];
    end else if (state_d == ST_MWRITE) begin
      dmem_addr_d = waddr_d;
    end
  end

  // Core state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      ir_q        <= '0;
      areg_q      <= '0;
      dreg_q      <= '0;
      wbuf_q      <= '0;
      waddr_q     <= '0;
      dmem_addr_q <= '0;
      dmem_re_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      areg_q      <= areg_d;
      dreg_q      <= dreg_d;
      wbuf_q      <= wbuf_d;
      waddr_q     <= waddr_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_re_q   <= dmem_re_d;
      dmem_we_q   <= dmem_we_d;
    end
  end

`ifdef HACK_HALT_DETECT_EN
  logic halted_q;
  logic halted_d;

  // Halt flag follows entry into the halt state
  always_comb begin
    halted_d = (state_d == ST_HALT);
  end

  // Halt flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign imem_addr  = pc;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = wbuf_q;
  assign dmem_re    = dmem_re_q;
  assign dmem_we    = dmem_we_q;

endmodule
